pheromone_decay_sweeper: RTL and testbench

PHEROMONE_DECAY_SWEEPER -- requirements
Module: pheromone_decay_sweeper

---
 rtl/pheromone_decay_sweeper_pkg.sv | 18 +
 rtl/pheromone_decay_sweeper_incrementer.sv | 27 ++
 rtl/pheromone_decay_sweeper.sv | 162 ++++++++++++++++
 tb/tb_pheromone_decay_sweeper.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pheromone_decay_sweeper_pkg.sv
// Shared parameters and state type for the pheromone decay sweeper.
// Grid geometry, pheromone width and decay strength live here so every file agrees.
package pheromone_decay_sweeper_pkg;

  localparam int PIXELS_X    = 4;
  localparam int PIXELS_Y    = 3;
  localparam int X_bits      = (PIXELS_X > 1) ? $clog2(PIXELS_X) : 1;
  localparam int Y_bits      = (PIXELS_Y > 1) ? $clog2(PIXELS_Y) : 1;
  localparam int PHER_bits   = 8;
  localparam int DECAY_SHIFT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/pheromone_decay_sweeper_incrementer.sv
// Raster-order location stepper: x runs fastest, and the last pixel wraps to (0,0).
// `last` flags the final location of a pass.
module pheromone_decay_sweeper_incrementer
  import pheromone_decay_sweeper_pkg::*;
(
  input  logic [X_bits-1:0] x,
  input  logic [Y_bits-1:0] y,
  output logic [X_bits-1:0] next_x,
  output logic [Y_bits-1:0] next_y,
  output logic              last
);

  logic x_wrap;
  logic y_wrap;

  always_comb begin
    x_wrap = (x == X_bits'(PIXELS_X - 1));
    y_wrap = (y == Y_bits'(PIXELS_Y - 1));
    last   = x_wrap && y_wrap;
    next_x = x_wrap ? '0 : x + 1'b1;
    next_y = y;
    if (x_wrap) begin
      next_y = y_wrap ? '0 : y + 1'b1;
    end
  end

endmodule

// File: rtl/pheromone_decay_sweeper.sv
// Sweeps the whole pheromone grid once per start, reading each cell and writing
// back its decayed value two cycles later; stall freezes the pipeline in place.
module pheromone_decay_sweeper
  import pheromone_decay_sweeper_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 stall,
  output logic                 rd_en,
  output logic [X_bits-1:0]    rd_x,
  output logic [Y_bits-1:0]    rd_y,
  input  logic [PHER_bits-1:0] rd_data,
  output logic                 wr_en,
  output logic [X_bits-1:0]    wr_x,
  output logic [Y_bits-1:0]    wr_y,
  output logic [PHER_bits-1:0] wr_data,
  output logic                 busy,
  output logic                 frame_done
);

  sweep_state_e state_q, state_d;

  logic [X_bits-1:0]    loc_x_q, loc_x_d, nxt_x;
  logic [Y_bits-1:0]    loc_y_q, loc_y_d, nxt_y;
  logic                 last_loc;

  logic                 rd_pend_q, rd_pend_d;
  logic [PHER_bits-1:0] hold_q, hold_d;

  logic                 s1_valid_q, s1_valid_d;
  logic [X_bits-1:0]    s1_x_q, s1_x_d;
  logic [Y_bits-1:0]    s1_y_q, s1_y_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [X_bits-1:0]    s2_x_q, s2_x_d;
  logic [Y_bits-1:0]    s2_y_q, s2_y_d;
  logic [PHER_bits-1:0] s2_data_q, s2_data_d;

  logic                 frame_done_q, frame_done_d;

  logic                 issue;
  logic                 retire_last;
  logic [PHER_bits-1:0] src_val;
  logic [PHER_bits-1:0] shift_val;
  logic [PHER_bits-1:0] decayed;

  pheromone_decay_sweeper_incrementer u_incrementer (
    .x      (loc_x_q),
    .y      (loc_y_q),
    .next_x (nxt_x),
    .next_y (nxt_y),
    .last   (last_loc)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      loc_x_q      <= '0;
      loc_y_q      <= '0;
      rd_pend_q    <= 1'b0;
      hold_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_x_q       <= '0;
      s2_y_q       <= '0;
      s2_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      loc_x_q      <= loc_x_d;
      loc_y_q      <= loc_y_d;
      rd_pend_q    <= rd_pend_d;
      hold_q       <= hold_d;
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s2_valid_q   <= s2_valid_d;
      s2_x_q       <= s2_x_d;
      s2_y_q       <= s2_y_d;
      s2_data_q    <= s2_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    issue       = (state_q == SWEEP) && !stall;
    retire_last = (state_q == DRAIN) && !stall && s2_valid_q && !s1_valid_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)              state_d = SWEEP;
      SWEEP:   if (issue && last_loc)  state_d = DRAIN;
      DRAIN:   if (retire_last)        state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    // Read data is only on the bus for one cycle; if the pipeline is stalled
    // when it arrives, hold_q keeps it until the stage can advance.
    src_val   = rd_pend_q ? rd_data : hold_q;
    shift_val = src_val >> DECAY_SHIFT;
    if (shift_val != '0) begin
      decayed = src_val - shift_val;
    end else if (src_val != '0) begin
      decayed = src_val - 1'b1;
    end else begin
      decayed = '0;
    end

    loc_x_d      = loc_x_q;
    loc_y_d      = loc_y_q;
    rd_pend_d    = issue;
    hold_d       = rd_pend_q ? rd_data : hold_q;
    s1_valid_d   = s1_valid_q;
    s1_x_d       = s1_x_q;
    s1_y_d       = s1_y_q;
    s2_valid_d   = s2_valid_q;
    s2_x_d       = s2_x_q;
    s2_y_d       = s2_y_q;
    s2_data_d    = s2_data_q;
    frame_done_d = retire_last;

    if (state_q == IDLE && start) begin
      loc_x_d = '0;
      loc_y_d = '0;
    end else if (issue) begin
      loc_x_d = nxt_x;
      loc_y_d = nxt_y;
    end

    if (!stall) begin
      s1_valid_d = issue;
      s1_x_d     = loc_x_q;
      s1_y_d     = loc_y_q;
      s2_valid_d = s1_valid_q;
      s2_x_d     = s1_x_q;
      s2_y_d     = s1_y_q;
      if (s1_valid_q) begin
        s2_data_d = decayed;
      end
    end
  end

  always_comb begin
    rd_en      = issue;
    rd_x       = loc_x_q;
    rd_y       = loc_y_q;
    wr_en      = s2_valid_q && !stall;
    wr_x       = s2_x_q;
    wr_y       = s2_y_q;
    wr_data    = s2_data_q;
    busy       = (state_q != IDLE);
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_pheromone_decay_sweeper.sv
// Self-checking bench for pheromone_decay_sweeper: a one-cycle-latency RAM model
// plus a raster-order reference of what each pass must write back.
module tb_pheromone_decay_sweeper;
  import pheromone_decay_sweeper_pkg::*;

  localparam int NPIX = PIXELS_X * PIXELS_Y;

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b1;
  logic                 start = 1'b0;
  logic                 stall = 1'b0;
  logic                 rd_en, wr_en, busy, frame_done;
  logic [X_bits-1:0]    rd_x, wr_x;
  logic [Y_bits-1:0]    rd_y, wr_y;
  logic [PHER_bits-1:0] rd_data = '0;
  logic [PHER_bits-1:0] wr_data;

  typedef struct {
    int x;
    int y;
    int data;
    int cyc;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  cyc = 0;
  int  fd_cnt = 0;
  int  fd_busy = 0;
  int  fd_prev_busy = 0;
  int  busy_last = 0;
  int  stall_strobes = 0;

  int  rd_base, wr_base, fd_base, ss_base;
  int  tests_run = 0;
  int  tests_failed = 0;

  logic [PHER_bits-1:0] mem [1<<Y_bits][1<<X_bits];
  int  pre_mem [PIXELS_Y][PIXELS_X];
  int  exp_mem [PIXELS_Y][PIXELS_X];
  bit  load_req = 1'b0;

  pheromone_decay_sweeper dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .stall      (stall),
    .rd_en      (rd_en),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 Clk = ~Clk;

  // Environment RAM: data valid one cycle after rd_en, garbage otherwise.
  always @(posedge Clk) begin
    cyc     <= cyc + 1;
    rd_data <= rd_en ? mem[rd_y][rd_x] : PHER_bits'($urandom);
    if (load_req) begin
      for (int y = 0; y < PIXELS_Y; y++)
        for (int x = 0; x < PIXELS_X; x++)
          mem[y][x] <= PHER_bits'(pre_mem[y][x]);
    end else if (wr_en) begin
      mem[wr_y][wr_x] <= wr_data;
    end
  end

  always @(negedge Clk) begin
    if (rd_en) rd_q.push_back('{int'(rd_x), int'(rd_y), 0, cyc});
    if (wr_en) begin
      wr_q.push_back('{int'(wr_x), int'(wr_y), int'(wr_data), cyc});
      $display("[TB] write (%0d,%0d) data=%0d cycle=%0d", wr_x, wr_y, wr_data, cyc);
    end
    if (stall && (rd_en || wr_en)) stall_strobes <= stall_strobes + 1;
    if (frame_done) begin
      fd_cnt       <= fd_cnt + 1;
      fd_busy      <= int'(busy);
      fd_prev_busy <= busy_last;
    end
    busy_last <= int'(busy);
  end

  function automatic int ref_decay(int v);
    int d;
    d = v / (1 << DECAY_SHIFT);
    if (d > 0) return v - d;
    if (v > 0) return v - 1;
    return 0;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_mem();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int y = 0; y < PIXELS_Y; y++)
      for (int x = 0; x < PIXELS_X; x++)
        exp_mem[y][x] = pre_mem[y][x];
  endtask

  task automatic fill_random();
    for (int y = 0; y < PIXELS_Y; y++)
      for (int x = 0; x < PIXELS_X; x++)
        pre_mem[y][x] = int'($urandom_range(0, 255));
  endtask

  task automatic mark();
    rd_base = rd_q.size();
    wr_base = wr_q.size();
    fd_base = fd_cnt;
    ss_base = stall_strobes;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (frame_done) begin
        timed_out = 1'b0;
        break;
      end
    end
    tick();
  endtask

  task automatic wait_reads(input int n, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (rd_q.size() - rd_base >= n) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    @(negedge Clk);
    tests_run++;
    if ({rd_en, wr_en, busy, frame_done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_strobes: got rd_en/wr_en/busy/frame_done=%b, expected 0000",
               {rd_en, wr_en, busy, frame_done});
    end
    tests_run++;
    if (rd_x !== '0 || rd_y !== '0 || wr_x !== '0 || wr_y !== '0 || wr_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_locations: got rd=(%0d,%0d) wr=(%0d,%0d) wr_data=%0d, expected all 0",
               rd_x, rd_y, wr_x, wr_y, wr_data);
    end
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_uniform();
    bit to;
    int n;
    for (int y = 0; y < PIXELS_Y; y++)
      for (int x = 0; x < PIXELS_X; x++)
        pre_mem[y][x] = 200;
    load_mem();
    mark();
    pulse_start();
    wait_done(200, to);
    repeat (5) tick();
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL uniform_timeout: frame_done not seen, expected within 200 cycles");
    end
    n = wr_q.size() - wr_base;
    tests_run++;
    if (n !== NPIX) begin
      tests_failed++;
      $display("FAIL uniform_write_count: got %0d, expected %0d", n, NPIX);
    end
    for (int i = 0; i < n && i < NPIX; i++) begin
      tests_run++;
      if (wr_q[wr_base+i].x !== i % PIXELS_X || wr_q[wr_base+i].y !== i / PIXELS_X ||
          wr_q[wr_base+i].data !== 175) begin
        tests_failed++;
        $display("FAIL uniform_write[%0d]: got (%0d,%0d)=%0d, expected (%0d,%0d)=175", i,
                 wr_q[wr_base+i].x, wr_q[wr_base+i].y, wr_q[wr_base+i].data,
                 i % PIXELS_X, i / PIXELS_X);
      end
      tests_run++;
      if (i < rd_q.size() - rd_base && wr_q[wr_base+i].cyc - rd_q[rd_base+i].cyc !== 2) begin
        tests_failed++;
        $display("FAIL uniform_latency[%0d]: got %0d cycles read->write, expected 2", i,
                 wr_q[wr_base+i].cyc - rd_q[rd_base+i].cyc);
      end
    end
    tests_run++;
    if (fd_cnt - fd_base !== 1) begin
      tests_failed++;
      $display("FAIL uniform_frame_done_count: got %0d, expected 1", fd_cnt - fd_base);
    end
    tests_run++;
    if (fd_busy !== 0 || fd_prev_busy !== 1) begin
      tests_failed++;
      $display("FAIL uniform_busy_edge: got busy=%0d at frame_done (prev %0d), expected 0 (prev 1)",
               fd_busy, fd_prev_busy);
    end
  endtask

  task automatic test_values();
    bit to;
    int n;
    int req [5];
    int exp_v;
    req = '{224, 7, 4, 0, 0};
    fill_random();
    pre_mem[0][0] = 255;
    pre_mem[0][1] = 8;
    pre_mem[0][2] = 5;
    pre_mem[0][3] = 1;
    pre_mem[1][0] = 0;
    load_mem();
    mark();
    pulse_start();
    wait_done(200, to);
    repeat (3) tick();
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL values_timeout: frame_done not seen, expected within 200 cycles");
    end
    n = wr_q.size() - wr_base;
    tests_run++;
    if (n !== NPIX) begin
      tests_failed++;
      $display("FAIL values_write_count: got %0d, expected %0d", n, NPIX);
    end
    for (int i = 0; i < n && i < NPIX; i++) begin
      exp_v = (i < 5) ? req[i] : ref_decay(exp_mem[i / PIXELS_X][i % PIXELS_X]);
      tests_run++;
      if (wr_q[wr_base+i].data !== exp_v) begin
        tests_failed++;
        $display("FAIL values_data[%0d]: got %0d from %0d, expected %0d", i,
                 wr_q[wr_base+i].data, exp_mem[i / PIXELS_X][i % PIXELS_X], exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to1, to2;
    int n, v, exp_v;
    fill_random();
    load_mem();
    mark();
    pulse_start();
    wait_done(200, to1);
    pulse_start();
    wait_done(200, to2);
    repeat (3) tick();
    tests_run++;
    if (to1 || to2) begin
      tests_failed++;
      $display("FAIL b2b_timeout: got timeouts %0d/%0d, expected 0/0", to1, to2);
    end
    n = wr_q.size() - wr_base;
    tests_run++;
    if (n !== 2 * NPIX || fd_cnt - fd_base !== 2) begin
      tests_failed++;
      $display("FAIL b2b_counts: got %0d writes %0d frame_done, expected %0d and 2",
               n, fd_cnt - fd_base, 2 * NPIX);
    end
    for (int i = 0; i < n && i < 2 * NPIX; i++) begin
      v     = exp_mem[(i % NPIX) / PIXELS_X][i % PIXELS_X];
      exp_v = (i < NPIX) ? ref_decay(v) : ref_decay(ref_decay(v));
      tests_run++;
      if (wr_q[wr_base+i].data !== exp_v || wr_q[wr_base+i].x !== i % PIXELS_X ||
          wr_q[wr_base+i].y !== (i % NPIX) / PIXELS_X) begin
        tests_failed++;
        $display("FAIL b2b_write[%0d]: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d", i,
                 wr_q[wr_base+i].x, wr_q[wr_base+i].y, wr_q[wr_base+i].data,
                 i % PIXELS_X, (i % NPIX) / PIXELS_X, exp_v);
      end
    end
  endtask

  task automatic test_stall();
    bit to_r, to;
    int n;
    fill_random();
    load_mem();
    mark();
    pulse_start();
    wait_reads(5, 50, to_r);
    tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    wait_done(200, to);
    repeat (3) tick();
    tests_run++;
    if (to_r || to) begin
      tests_failed++;
      $display("FAIL stall_timeout: got timeouts %0d/%0d, expected 0/0", to_r, to);
    end
    tests_run++;
    if (stall_strobes - ss_base !== 0) begin
      tests_failed++;
      $display("FAIL stall_strobes: got %0d strobes during stall, expected 0",
               stall_strobes - ss_base);
    end
    tests_run++;
    if (rd_q.size() - rd_base < 6 || rd_q[rd_base+5].x !== 1 || rd_q[rd_base+5].y !== 1) begin
      tests_failed++;
      $display("FAIL stall_resume_loc: got %0d reads, 6th read not at (1,1), expected (1,1)",
               rd_q.size() - rd_base);
    end
    n = wr_q.size() - wr_base;
    tests_run++;
    if (n !== NPIX || rd_q.size() - rd_base !== NPIX) begin
      tests_failed++;
      $display("FAIL stall_counts: got %0d writes %0d reads, expected %0d each",
               n, rd_q.size() - rd_base, NPIX);
    end
    for (int i = 0; i < n && i < NPIX; i++) begin
      tests_run++;
      if (wr_q[wr_base+i].x !== i % PIXELS_X || wr_q[wr_base+i].y !== i / PIXELS_X ||
          wr_q[wr_base+i].data !== ref_decay(exp_mem[i / PIXELS_X][i % PIXELS_X])) begin
        tests_failed++;
        $display("FAIL stall_write[%0d]: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d", i,
                 wr_q[wr_base+i].x, wr_q[wr_base+i].y, wr_q[wr_base+i].data,
                 i % PIXELS_X, i / PIXELS_X, ref_decay(exp_mem[i / PIXELS_X][i % PIXELS_X]));
      end
    end
  endtask

  task automatic test_random_stall();
    bit to;
    int n;
    fill_random();
    load_mem();
    mark();
    pulse_start();
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 2) == 0);
      @(negedge Clk);
      if (frame_done) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    stall = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL rstall_timeout: frame_done not seen, expected within 400 cycles");
    end
    tests_run++;
    if (stall_strobes - ss_base !== 0 || fd_cnt - fd_base !== 1) begin
      tests_failed++;
      $display("FAIL rstall_strobes: got %0d stalled strobes %0d frame_done, expected 0 and 1",
               stall_strobes - ss_base, fd_cnt - fd_base);
    end
    n = wr_q.size() - wr_base;
    tests_run++;
    if (n !== NPIX) begin
      tests_failed++;
      $display("FAIL rstall_write_count: got %0d, expected %0d", n, NPIX);
    end
    for (int i = 0; i < n && i < NPIX; i++) begin
      tests_run++;
      if (wr_q[wr_base+i].x !== i % PIXELS_X || wr_q[wr_base+i].y !== i / PIXELS_X ||
          wr_q[wr_base+i].data !== ref_decay(exp_mem[i / PIXELS_X][i % PIXELS_X])) begin
        tests_failed++;
        $display("FAIL rstall_write[%0d]: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d", i,
                 wr_q[wr_base+i].x, wr_q[wr_base+i].y, wr_q[wr_base+i].data,
                 i % PIXELS_X, i / PIXELS_X, ref_decay(exp_mem[i / PIXELS_X][i % PIXELS_X]));
      end
    end
  endtask

  task automatic test_reset_mid_pass();
    bit to_r, to;
    int n;
    fill_random();
    load_mem();
    mark();
    pulse_start();
    wait_reads(6, 50, to_r);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    tests_run++;
    if (to_r || wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_after: got wr_en=%b rd_en=%b busy=%b (read timeout %0d), expected 0 0 0 0",
               wr_en, rd_en, busy, to_r);
    end
    tick();
    load_mem();
    mark();
    pulse_start();
    wait_done(200, to);
    repeat (3) tick();
    tests_run++;
    if (to || rd_q.size() == rd_base || rd_q[rd_base].x !== 0 || rd_q[rd_base].y !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_restart: got timeout=%0d, first read not at (0,0), expected (0,0)",
               to);
    end
    n = wr_q.size() - wr_base;
    tests_run++;
    if (n !== NPIX || fd_cnt - fd_base !== 1) begin
      tests_failed++;
      $display("FAIL reset_mid_counts: got %0d writes %0d frame_done, expected %0d and 1",
               n, fd_cnt - fd_base, NPIX);
    end
    for (int i = 0; i < n && i < NPIX; i++) begin
      tests_run++;
      if (wr_q[wr_base+i].x !== i % PIXELS_X || wr_q[wr_base+i].y !== i / PIXELS_X ||
          wr_q[wr_base+i].data !== ref_decay(exp_mem[i / PIXELS_X][i % PIXELS_X])) begin
        tests_failed++;
        $display("FAIL reset_mid_write[%0d]: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d", i,
                 wr_q[wr_base+i].x, wr_q[wr_base+i].y, wr_q[wr_base+i].data,
                 i % PIXELS_X, i / PIXELS_X, ref_decay(exp_mem[i / PIXELS_X][i % PIXELS_X]));
      end
    end
  endtask

  task automatic test_double_start();
    bit to;
    fill_random();
    load_mem();
    mark();
    pulse_start();
    repeat (4) tick();
    pulse_start();
    wait_done(200, to);
    repeat (20) tick();
    tests_run++;
    if (to || fd_cnt - fd_base !== 1) begin
      tests_failed++;
      $display("FAIL double_start_frame_done: got %0d (timeout %0d), expected 1",
               fd_cnt - fd_base, to);
    end
    tests_run++;
    if (wr_q.size() - wr_base !== NPIX || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL double_start_writes: got %0d writes busy=%b, expected %0d busy=0",
               wr_q.size() - wr_base, busy, NPIX);
    end
  endtask

  task automatic test_start_with_reset();
    mark();
    Reset = 1'b1;
    start = 1'b1;
    tick();
    Reset = 1'b0;
    start = 1'b0;
    @(negedge Clk);
    tests_run++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_reset_idle: got busy=%b rd_en=%b, expected 0 0", busy, rd_en);
    end
    tick();
    repeat (5) tick();
    tests_run++;
    if (busy !== 1'b0 || rd_q.size() - rd_base !== 0) begin
      tests_failed++;
      $display("FAIL start_reset_stays: got busy=%b reads=%0d, expected 0 0",
               busy, rd_q.size() - rd_base);
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_values();
    test_back_to_back();
    test_stall();
    test_random_stall();
    test_reset_mid_pass();
    test_double_start();
    test_start_with_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
